// File: rtl/gate_bist_pkg.sv
// Shared constants for the NOT/AND/OR gate-block BIST: FSM states, vector sizing, mask layout.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned VEC_W   = 2;
  localparam int unsigned NUM_VEC = 4;

  // Bit positions inside the {not,and,or} expected/observed/mismatch vectors.
  localparam int unsigned MASK_NOT = 2;
  localparam int unsigned MASK_AND = 1;
  localparam int unsigned MASK_OR  = 0;

endpackage

// File: rtl/gate_golden_model.sv
// Reference behaviour of the three-output gate block: {not,and,or} from {A,B}.
module gate_golden_model
  import gate_bist_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [2:0] expected
);

  always_comb begin
    expected           = '0;
    expected[MASK_NOT] = ~a;
    expected[MASK_AND] = a & b;
    expected[MASK_OR]  = a | b;
  end

endmodule

// File: rtl/gate_bist_checker.sv
// BIST controller: sweeps all {A,B} vectors into the gate block, checks the outputs against the
// golden model, counts mismatches and captures the first failure of each run.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_not,
  input  logic             dut_and,
  input  logic             dut_or,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [2:0]       first_fail_bits
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [7:0]         loop_q, loop_d;
  logic [7:0]         settle_q, settle_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               any_err_q, any_err_d;
  logic               fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]   ffv_q, ffv_d;
  logic [2:0]         ffb_q, ffb_d;

  logic [2:0] exp_bits;
  logic [2:0] obs_bits;
  logic [2:0] mask;
  logic       mismatch;

  gate_golden_model u_golden (
    .a        (vec_q[1]),
    .b        (vec_q[0]),
    .expected (exp_bits)
  );

  always_comb begin
    obs_bits           = '0;
    obs_bits[MASK_NOT] = dut_not;
    obs_bits[MASK_AND] = dut_and;
    obs_bits[MASK_OR]  = dut_or;
  end

  // An X/Z observed bit makes the equality test unknown, which falls to the mismatch branch.
  always_comb begin
    mask = obs_bits ^ exp_bits;
    if (mask == 3'b000) mismatch = 1'b0;
    else                mismatch = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    loop_d       = loop_q;
    settle_d     = settle_q;
    err_d        = err_q;
    any_err_d    = any_err_q;
    fail_valid_d = fail_valid_q;
    ffv_d        = ffv_q;
    ffb_d        = ffb_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = APPLY;
          vec_d        = '0;
          loop_d       = '0;
          err_d        = '0;
          any_err_d    = 1'b0;
          fail_valid_d = 1'b0;
          ffv_d        = '0;
          ffb_d        = '0;
        end
      end
      APPLY: begin
        state_d  = SETTLE;
        settle_d = 8'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        if (settle_q == 8'd0) state_d = CHECK;
        else                  settle_d = settle_q - 8'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          any_err_d = 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            ffv_d        = vec_q;
            ffb_d        = mask;
          end
        end
        if (vec_q != VEC_W'(NUM_VEC - 1)) begin
          vec_d   = vec_q + 1'b1;
          state_d = APPLY;
        end else if (loop_q < 8'(LOOPS - 1)) begin
          vec_d   = '0;
          loop_d  = loop_q + 8'd1;
          state_d = APPLY;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      loop_q       <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      any_err_q    <= 1'b0;
      fail_valid_q <= 1'b0;
      ffv_q        <= '0;
      ffb_q        <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      loop_q       <= loop_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      any_err_q    <= any_err_d;
      fail_valid_q <= fail_valid_d;
      ffv_q        <= ffv_d;
      ffb_q        <= ffb_d;
    end
  end

  // All outputs decode registered state only, so nothing reaches them from the DUT inputs.
  assign dut_a           = vec_q[1];
  assign dut_b           = vec_q[0];
  assign busy            = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign done            = (state_q == DONE);
  assign pass            = (state_q == DONE) && !any_err_q;
  assign err_count       = err_q;
  assign fail_valid      = fail_valid_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_bits = ffb_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench: each run queues its expected result; a monitor checks it when done rises.
module tb_gate_bist_checker;

  typedef struct {
    logic [7:0]  err;
    logic        pass;
    logic        fv;
    logic [1:0]  vec;
    logic [2:0]  bits;
    int          cycles;
    logic [31:0] seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   fault = 0;
  int   sel = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Fault modes: 0 good, 1 AND stuck-0, 2 NOT inverted, 3 OR stuck-1, 4 all inverted.
  function automatic logic [2:0] gate_resp(input logic a, input logic b, input int f);
    logic [2:0] r;
    r = {~a, a & b, a | b};
    case (f)
      1: r[1] = 1'b0;
      2: r[2] = ~r[2];
      3: r[0] = 1'b1;
      4: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  function automatic exp_t mk(input logic [7:0] err, input logic p, input logic fv,
                              input logic [1:0] v, input logic [2:0] b, input int cyc,
                              input logic [31:0] seq);
    exp_t e;
    e.err = err; e.pass = p; e.fv = fv; e.vec = v; e.bits = b; e.cycles = cyc; e.seq = seq;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Three instances cover the default, multi-loop and narrow-counter configurations.
  logic a0, b0, busy0, done0, pass0, fv0;
  logic a1, b1, busy1, done1, pass1, fv1;
  logic a2, b2, busy2, done2, pass2, fv2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [1:0] vec0, vec1, vec2;
  logic [2:0] bits0, bits1, bits2;
  logic [2:0] r0, r1, r2;

  assign r0 = gate_resp(a0, b0, fault);
  assign r1 = gate_resp(a1, b1, fault);
  assign r2 = gate_resp(a2, b2, fault);

  gate_bist_checker u_dut (
    .clk (clk), .rst_n (rst_n), .start (start), .dut_a (a0), .dut_b (b0),
    .dut_not (r0[2]), .dut_and (r0[1]), .dut_or (r0[0]), .busy (busy0), .done (done0),
    .pass (pass0), .err_count (err0), .fail_valid (fv0), .first_fail_vec (vec0),
    .first_fail_bits (bits0)
  );

  gate_bist_checker #(.LOOPS(3)) u_dut_l3 (
    .clk (clk), .rst_n (rst_n), .start (start), .dut_a (a1), .dut_b (b1),
    .dut_not (r1[2]), .dut_and (r1[1]), .dut_or (r1[0]), .busy (busy1), .done (done1),
    .pass (pass1), .err_count (err1), .fail_valid (fv1), .first_fail_vec (vec1),
    .first_fail_bits (bits1)
  );

  gate_bist_checker #(.ERR_W(2), .LOOPS(2)) u_dut_sat (
    .clk (clk), .rst_n (rst_n), .start (start), .dut_a (a2), .dut_b (b2),
    .dut_not (r2[2]), .dut_and (r2[1]), .dut_or (r2[0]), .busy (busy2), .done (done2),
    .pass (pass2), .err_count (err2), .fail_valid (fv2), .first_fail_vec (vec2),
    .first_fail_bits (bits2)
  );

  logic m_a, m_b, m_busy, m_done, m_pass, m_fv;
  logic [7:0] m_err;
  logic [1:0] m_vec;
  logic [2:0] m_bits;

  always_comb begin
    {m_a, m_b, m_busy, m_done, m_pass, m_fv} = {a0, b0, busy0, done0, pass0, fv0};
    m_err = err0; m_vec = vec0; m_bits = bits0;
    if (sel == 1) begin
      {m_a, m_b, m_busy, m_done, m_pass, m_fv} = {a1, b1, busy1, done1, pass1, fv1};
      m_err = err1; m_vec = vec1; m_bits = bits1;
    end else if (sel == 2) begin
      {m_a, m_b, m_busy, m_done, m_pass, m_fv} = {a2, b2, busy2, done2, pass2, fv2};
      m_err = {6'd0, err2}; m_vec = vec2; m_bits = bits2;
    end
  end

  // Monitor: tracks busy length and the applied vector sequence, checks on done rising.
  logic        prev_busy = 1'b0, prev_done = 1'b0;
  logic [1:0]  prev_ab = 2'b00;
  int          busy_cycles = 0;
  logic [31:0] seq = '0;

  always @(negedge clk) begin
    exp_t e;
    if (m_busy && !prev_busy) begin
      busy_cycles = 1;
      seq = {30'd0, m_a, m_b};
    end else if (m_busy) begin
      busy_cycles++;
      if ({m_a, m_b} != prev_ab) seq = {seq[29:0], m_a, m_b};
    end
    if (m_done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("err_count", {24'd0, m_err}, {24'd0, e.err});
        check("pass", {31'd0, m_pass}, {31'd0, e.pass});
        check("fail_valid", {31'd0, m_fv}, {31'd0, e.fv});
        check("first_fail_vec", {30'd0, m_vec}, {30'd0, e.vec});
        check("first_fail_bits", {29'd0, m_bits}, {29'd0, e.bits});
        check("latency", busy_cycles, e.cycles);
        check("vector_seq", seq, e.seq);
      end
    end
    prev_busy = m_busy;
    prev_done = m_done;
    prev_ab   = {m_a, m_b};
  end

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input int s, input int f, input exp_t e, input int extra);
    int t;
    sel = s;
    fault = f;
    exp_q.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_done_after_start", {30'd0, m_busy, m_done}, 32'd2);
    if (extra > 0) begin
      repeat (extra) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    t = 0;
    while (!m_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, m_done}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {m_a, m_b, m_busy, m_done, m_pass, m_err, m_fv, m_vec, m_bits}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 0, mk(8'd0, 1'b1, 1'b0, 2'b00, 3'b000, 16, 32'h1B), 0);
    run(0, 0, mk(8'd0, 1'b1, 1'b0, 2'b00, 3'b000, 16, 32'h1B), 0);
    run(0, 1, mk(8'd1, 1'b0, 1'b1, 2'b11, 3'b010, 16, 32'h1B), 0);
    run(0, 2, mk(8'd4, 1'b0, 1'b1, 2'b00, 3'b100, 16, 32'h1B), 0);
    run(0, 0, mk(8'd0, 1'b1, 1'b0, 2'b00, 3'b000, 16, 32'h1B), 4);

    pulse_reset();
    run(1, 3, mk(8'd3, 1'b0, 1'b1, 2'b00, 3'b001, 48, 32'h1B1B1B), 0);

    pulse_reset();
    run(2, 4, mk(8'd3, 1'b0, 1'b1, 2'b00, 3'b111, 32, 32'h1B1B), 0);

    // Abort a good run mid-sweep; its queued result must never be observed.
    pulse_reset();
    sel = 0;
    fault = 0;
    exp_q.push_back(mk(8'd0, 1'b1, 1'b0, 2'b00, 3'b000, 16, 32'h1B));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {m_a, m_b, m_busy, m_done, m_pass, m_err, m_fv, m_vec, m_bits}, 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run(0, 0, mk(8'd0, 1'b1, 1'b0, 2'b00, 3'b000, 16, 32'h1B), 0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
